sram_ctrl_fsm: RTL and testbench

Parametrised SRAM subsystem controller FSM. It accepts power and access commands from a client over ready/valid, and collects address/data words on a second ready/valid channel. It drives a single-port SRAM macro with configurable read latency and returns read data on a ready/valid output channel. It is the generalised successor of the fixed 16-bit client state machine, adding real SRAM access, backpressure and illegal-command reporting.

---
 rtl/sram_ctrl_fsm.sv | 154 +++++++++++++++
 tb/tb_sram_ctrl_fsm.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_fsm.sv
// rtl/sram_ctrl_fsm.sv - SRAM subsystem controller FSM with power, access and read-return channels
module sram_ctrl_fsm #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 9,
    parameter int CMD_WIDTH    = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CMD_WIDTH-1:0]  cmd,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  sram_pwr_en,
    output logic                  sram_en,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  illegal_cmd,
    output logic [2:0]            current_state
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST     = CNT_W'(READ_LATENCY);
    localparam logic [CMD_WIDTH-1:0] OP_POWER_OFF = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] OP_POWER_ON  = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] OP_READ      = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] OP_WRITE     = CMD_WIDTH'(3);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_IDLE     = 3'd1,
        S_GET_ADDR = 3'd2,
        S_GET_DATA = 3'd3,
        S_WR_ISSUE = 3'd4,
        S_RD_ISSUE = 3'd5,
        S_RD_WAIT  = 3'd6,
        S_SEND     = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_illegal;
    logic                  r_illegal;
    logic                  r_is_write;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  w_cmd_hs;
    logic                  w_din_hs;
    logic                  w_rd_done;

    // Ready and SRAM strobes are pure state decodes, so no input reaches an output combinationally
    assign cmd_ready     = (r_state == S_OFF) || (r_state == S_IDLE);
    assign din_ready     = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    assign dout_valid    = (r_state == S_SEND);
    assign sram_pwr_en   = (r_state != S_OFF);
    assign sram_en       = (r_state == S_WR_ISSUE) || (r_state == S_RD_ISSUE);
    assign sram_wen      = (r_state == S_WR_ISSUE);
    assign sram_addr     = r_addr;
    assign sram_wdata    = r_wdata;
    assign dout          = r_dout;
    assign illegal_cmd   = r_illegal;
    assign current_state = r_state;

    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_din_hs  = din_valid && din_ready;
    assign w_rd_done = (r_state == S_RD_WAIT) && (r_cnt == CNT_LAST);

    // State register
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and illegal-command detection
    always_comb begin
        w_next_state = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            S_OFF: begin
                if (w_cmd_hs) begin
                    if (cmd == OP_POWER_ON) w_next_state = S_IDLE;
                    else                    w_illegal    = 1'b1;
                end
            end
            S_IDLE: begin
                if (w_cmd_hs) begin
                    if (cmd == OP_POWER_OFF)                     w_next_state = S_OFF;
                    else if ((cmd == OP_READ) || (cmd == OP_WRITE)) w_next_state = S_GET_ADDR;
                    else if (cmd != OP_POWER_ON)                 w_illegal    = 1'b1;
                end
            end
            S_GET_ADDR: begin
                if (w_din_hs) w_next_state = r_is_write ? S_GET_DATA : S_RD_ISSUE;
            end
            S_GET_DATA: begin
                if (w_din_hs) w_next_state = S_WR_ISSUE;
            end
            S_WR_ISSUE: w_next_state = S_IDLE;
            S_RD_ISSUE: w_next_state = S_RD_WAIT;
            S_RD_WAIT: begin
                if (w_rd_done) w_next_state = S_SEND;
            end
            S_SEND: begin
                if (dout_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_OFF;
        endcase
    end

    // Operation latch, address/data capture, read-latency counter and read-data capture
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_illegal  <= 1'b0;
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dout     <= '0;
        end else begin
            r_illegal <= w_illegal;
            if ((r_state == S_IDLE) && w_cmd_hs) begin
                r_is_write <= (cmd == OP_WRITE);
            end
            if ((r_state == S_GET_ADDR) && w_din_hs) begin
                r_addr <= din[ADDR_WIDTH-1:0];
            end
            if ((r_state == S_GET_DATA) && w_din_hs) begin
                r_wdata <= din;
            end
            // Counter holds the index of the current wait cycle, 1..READ_LATENCY
            if (r_state == S_RD_ISSUE) begin
                r_cnt <= CNT_W'(1);
            end else if ((r_state == S_RD_WAIT) && !w_rd_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_rd_done) begin
                r_dout <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl_fsm.sv
// tb/tb_sram_ctrl_fsm.sv - randomized model-checked bench for sram_ctrl_fsm at read latencies 1 and 3
module tb_sram_ctrl_fsm;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic        CLK;
    logic        rstn;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic        din_valid;
    logic [15:0] din;
    logic        dout_ready;

    logic        o_cr    [2];
    logic        o_dr    [2];
    logic        o_dv    [2];
    logic [15:0] o_dout  [2];
    logic        o_pwr   [2];
    logic        o_en    [2];
    logic        o_wen   [2];
    logic [8:0]  o_addr  [2];
    logic [15:0] o_wdata [2];
    logic [15:0] s_rdata [2];
    logic        o_ill   [2];
    logic [2:0]  o_st    [2];

    logic        e_cr    [2];
    logic        e_dr    [2];
    logic        e_dv    [2];
    logic [15:0] e_dout  [2];
    logic        e_pwr   [2];
    logic        e_en    [2];
    logic        e_wen   [2];
    logic [8:0]  e_addr  [2];
    logic [15:0] e_wdata [2];
    logic        e_ill   [2];
    logic [2:0]  e_st    [2];

    bit          m_pwr;
    logic [8:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_dout [2];
    logic [15:0] m_mem  [512];
    logic [8:0]  written[$];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? LAT_A : LAT_B;
        logic [15:0] mem  [512];
        logic [15:0] pipe [LAT];

        sram_ctrl_fsm #(
            .DATA_WIDTH  (16),
            .ADDR_WIDTH  (9),
            .CMD_WIDTH   (4),
            .READ_LATENCY(LAT)
        ) u_dut (
            .CLK          (CLK),
            .ASYNCRESETN  (rstn),
            .cmd_valid    (cmd_valid),
            .cmd_ready    (o_cr[g]),
            .cmd          (cmd),
            .din_valid    (din_valid),
            .din_ready    (o_dr[g]),
            .din          (din),
            .dout_valid   (o_dv[g]),
            .dout_ready   (dout_ready),
            .dout         (o_dout[g]),
            .sram_pwr_en  (o_pwr[g]),
            .sram_en      (o_en[g]),
            .sram_wen     (o_wen[g]),
            .sram_addr    (o_addr[g]),
            .sram_wdata   (o_wdata[g]),
            .sram_rdata   (s_rdata[g]),
            .illegal_cmd  (o_ill[g]),
            .current_state(o_st[g])
        );

        // SRAM macro: rdata valid LAT clocks after a read enable, garbage otherwise
        always @(posedge CLK) begin
            if (o_en[g] && o_wen[g]) mem[o_addr[g]] <= o_wdata[g];
            pipe[0] <= (o_en[g] && !o_wen[g]) ? mem[o_addr[g]] : 16'($urandom);
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign s_rdata[g] = pipe[LAT-1];
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Every cycle: all outputs of both instances against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("cmd_ready",   i, 16'(o_cr[i]),    16'(e_cr[i]));
                chk("din_ready",   i, 16'(o_dr[i]),    16'(e_dr[i]));
                chk("dout_valid",  i, 16'(o_dv[i]),    16'(e_dv[i]));
                chk("dout",        i, o_dout[i],       e_dout[i]);
                chk("sram_pwr_en", i, 16'(o_pwr[i]),   16'(e_pwr[i]));
                chk("sram_en",     i, 16'(o_en[i]),    16'(e_en[i]));
                chk("sram_wen",    i, 16'(o_wen[i]),   16'(e_wen[i]));
                chk("sram_addr",   i, 16'(o_addr[i]),  16'(e_addr[i]));
                chk("sram_wdata",  i, o_wdata[i],      e_wdata[i]);
                chk("illegal_cmd", i, 16'(o_ill[i]),   16'(e_ill[i]));
                chk("state",       i, 16'(o_st[i]),    16'(e_st[i]));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        e_ill[0] = 1'b0;
        e_ill[1] = 1'b0;
    endtask

    // Expected outputs of one instance given which spec state it occupies
    task automatic set_phase(input int i, input int st);
        e_st[i]    = 3'(st);
        e_cr[i]    = (st == 0) || (st == 1);
        e_dr[i]    = (st == 2) || (st == 3);
        e_pwr[i]   = (st != 0);
        e_en[i]    = (st == 4) || (st == 5);
        e_wen[i]   = (st == 4);
        e_dv[i]    = (st == 7);
        e_addr[i]  = m_addr;
        e_wdata[i] = m_wdata;
        e_dout[i]  = m_dout[i];
    endtask

    task automatic both(input int st);
        set_phase(0, st);
        set_phase(1, st);
    endtask

    task automatic do_cmd(input logic [3:0] op);
        cmd_valid = 1'b1;
        cmd       = op;
        tick();
        cmd_valid = 1'b0;
        cmd       = 4'($urandom);
        if (!m_pwr) begin
            if (op == 4'd1) begin
                m_pwr = 1'b1;
                both(1);
            end else begin
                both(0);
                e_ill[0] = 1'b1;
                e_ill[1] = 1'b1;
            end
        end else if (op == 4'd0) begin
            m_pwr = 1'b0;
            both(0);
        end else if (op == 4'd2 || op == 4'd3) begin
            both(2);
        end else begin
            both(1);
            if (op != 4'd1) begin
                e_ill[0] = 1'b1;
                e_ill[1] = 1'b1;
            end
        end
    endtask

    task automatic give_din(input logic [15:0] v);
        repeat ($urandom_range(0, 3)) begin
            din_valid = 1'b0;
            din       = 16'($urandom);
            cmd_valid = 1'($urandom);
            cmd       = 4'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        din_valid = 1'b1;
        din       = v;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input bit pin);
        do_cmd(4'd3);
        give_din(a);
        m_addr = a[8:0];
        both(3);
        give_din(d);
        m_wdata = d;
        both(4);
        if (pin) begin
            chk("pin_wr_en",    0, 16'(o_en[0]),    16'h0001);
            chk("pin_wr_wen",   0, 16'(o_wen[0]),   16'h0001);
            chk("pin_wr_addr",  0, 16'(o_addr[0]),  16'h0005);
            chk("pin_wr_wdata", 0, o_wdata[0],      16'hBEEF);
        end
        tick();
        m_mem[m_addr] = m_wdata;
        written.push_back(m_addr);
        both(1);
    endtask

    task automatic async_reset_now();
        #2;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_state", i, 16'(o_st[i]),  16'h0000);
            chk("rst_en",    i, 16'(o_en[i]),  16'h0000);
            chk("rst_pwr",   i, 16'(o_pwr[i]), 16'h0000);
            chk("rst_dv",    i, 16'(o_dv[i]),  16'h0000);
        end
        m_pwr     = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_dout[0] = '0;
        m_dout[1] = '0;
        both(0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (6) tick();
    endtask

    task automatic do_read(input logic [15:0] a, input bit pin, input bit rst_mid);
        bit done [2];
        bit rdy;
        int c;
        do_cmd(4'd2);
        give_din(a);
        m_addr = a[8:0];
        both(5);
        if (pin) begin
            chk("pin_rd_en",  0, 16'(o_en[0]),  16'h0001);
            chk("pin_rd_wen", 0, 16'(o_wen[0]), 16'h0000);
        end
        if (rst_mid) begin
            tick();
            both(6);
            async_reset_now();
            return;
        end
        done[0] = 1'b0;
        done[1] = 1'b0;
        c = 0;
        while (!(done[0] && done[1])) begin
            if (c < 7)       rdy = 1'b0;
            else if (c > 40) rdy = 1'b1;
            else             rdy = 1'($urandom);
            dout_ready = rdy;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!done[i]) begin
                    if (c >= lat_of(i) + 1 && rdy) begin
                        done[i] = 1'b1;
                        set_phase(i, 1);
                    end else if (c + 1 <= lat_of(i)) begin
                        set_phase(i, 6);
                    end else begin
                        m_dout[i] = m_mem[m_addr];
                        set_phase(i, 7);
                    end
                end
            end
            if (pin) begin
                if (c == 0) chk("pin_dv_t1_l1", 0, 16'(o_dv[0]), 16'h0000);
                if (c == 1) begin
                    chk("pin_dv_t2_l1",   0, 16'(o_dv[0]), 16'h0001);
                    chk("pin_dout_t2_l1", 0, o_dout[0],    16'hBEEF);
                    chk("pin_dv_t2_l3",   1, 16'(o_dv[1]), 16'h0000);
                end
                if (c == 3) begin
                    chk("pin_dv_t4_l3",   1, 16'(o_dv[1]), 16'h0001);
                    chk("pin_dout_t4_l3", 1, o_dout[1],    16'hBEEF);
                end
            end
            c++;
        end
        dout_ready = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        cmd_valid  = 1'b0;
        cmd        = '0;
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        m_pwr      = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_dout[0]  = '0;
        m_dout[1]  = '0;
        e_ill[0]   = 1'b0;
        e_ill[1]   = 1'b0;
        both(0);
        chk_en = 1'b1;

        tick();
        tick();
        chk("pin_reset_state", 0, 16'(o_st[0]),  16'h0000);
        chk("pin_reset_pwr",   0, 16'(o_pwr[0]), 16'h0000);
        chk("pin_reset_dout",  0, o_dout[0],     16'h0000);
        rstn = 1'b1;
        tick();

        do_cmd(4'd2);
        chk("pin_ill_off",       0, 16'(o_ill[0]), 16'h0001);
        chk("pin_ill_off_state", 0, 16'(o_st[0]),  16'h0000);
        tick();
        chk("pin_ill_pulse_end", 0, 16'(o_ill[0]), 16'h0000);

        do_cmd(4'd1);
        chk("pin_on_state", 0, 16'(o_st[0]),  16'h0001);
        chk("pin_on_pwr",   0, 16'(o_pwr[0]), 16'h0001);

        do_cmd(4'd9);
        chk("pin_ill_idle",       0, 16'(o_ill[0]), 16'h0001);
        chk("pin_ill_idle_state", 0, 16'(o_st[0]),  16'h0001);
        tick();

        do_write(16'h0005, 16'hBEEF, 1'b1);
        do_read(16'h0005, 1'b1, 1'b0);
        do_write(16'hFFFF, 16'h1234, 1'b0);
        chk("pin_addr_trunc", 0, 16'(o_addr[0]), 16'h01FF);

        for (int n = 0; n < 40; n++) begin
            int r;
            repeat ($urandom_range(0, 2)) begin
                din_valid = 1'($urandom);
                din       = 16'($urandom);
                tick();
            end
            din_valid = 1'b0;
            r = $urandom_range(0, 9);
            if (!m_pwr) begin
                if (r < 7) do_cmd(4'd1);
                else       do_cmd(4'($urandom_range(0, 15)));
            end else if (r < 4) begin
                do_write({7'($urandom), 9'($urandom_range(0, 15))}, 16'($urandom), 1'b0);
            end else if (r < 7) begin
                do_read({7'($urandom), written[$urandom_range(0, written.size() - 1)]}, 1'b0, 1'b0);
            end else if (r == 7) begin
                do_cmd(4'($urandom_range(4, 15)));
            end else if (r == 8) begin
                do_cmd(4'd1);
            end else begin
                do_cmd(4'd0);
            end
        end

        if (!m_pwr) do_cmd(4'd1);
        do_read({7'd0, written[0]}, 1'b0, 1'b1);
        do_cmd(4'd1);
        do_read(16'h0005, 1'b0, 1'b0);
        repeat (3) tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
